// File: rtl/sm3_expnd_pkg.sv
// Shared definitions for the SM3 message-expansion engine.
//   state_t  : expander FSM state (LOAD collects a block, EXPND emits words)
//   SM3_*    : block / expansion / emitted word counts
//   rotl32   : 32-bit rotate left
//   p1       : SM3 permutation P1(x) = x ^ (x <<< 15) ^ (x <<< 23)
package sm3_expnd_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        EXPND = 1'b1
    } state_t;

    localparam int SM3_BLK_W = 16;  // words per padded block
    localparam int SM3_EXP_W = 68;  // W[0..67]; W[64..67] only feed W'[60..63]
    localparam int SM3_OUT_W = 64;  // (Wj, W'j) pairs emitted per block

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rotl32(x, 15) ^ rotl32(x, 23);
    endfunction

endpackage

// File: rtl/sm3_expnd_wgen.sv
// Combinational SM3 next-word generator.
//   W[n] = P1(W[n-16] ^ W[n-9] ^ (W[n-3] <<< 15)) ^ (W[n-13] <<< 7) ^ W[n-6]
// Ports:
//   w_m16, w_m13, w_m9, w_m6, w_m3 : in  window words W[n-16] .. W[n-3]
//   w_new                          : out W[n]
module sm3_expnd_wgen
    import sm3_expnd_pkg::*;
(
    input  logic [31:0] w_m16,
    input  logic [31:0] w_m13,
    input  logic [31:0] w_m9,
    input  logic [31:0] w_m6,
    input  logic [31:0] w_m3,
    output logic [31:0] w_new
);

    assign w_new = p1(w_m16 ^ w_m9 ^ rotl32(w_m3, 15)) ^ rotl32(w_m13, 7) ^ w_m6;

endmodule

// File: rtl/sm3_msg_expnd.sv
// SM3 message-expansion engine. Collects a 512-bit padded block in
// INPT_DW-bit beats, then emits the 64 (Wj, W'j) pairs LANES words per beat.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never depends on ready, and an offered output beat is held
// stable (data, lst, end) until it transfers.
//
// Parameters: INPT_DW = 32 | 64, LANES = 1 | 2.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   pad_inpt_d_i       : in  block beat, big-endian (MS word = lower index)
//   pad_inpt_vld_i     : in  beat valid
//   pad_inpt_lst_i     : in  message-last flag, sampled with the final beat
//   pad_inpt_rdy_o     : out input ready (0 while rst is high)
//   expnd_otpt_wj_o    : out W[j..j+LANES-1], MS word = lowest j
//   expnd_otpt_wjj_o   : out W'[j..j+LANES-1] = W ^ W[+4]
//   expnd_otpt_vld_o   : out output beat valid
//   expnd_otpt_rdy_i   : in  downstream ready
//   expnd_otpt_lst_o   : out message-last flag of the block being emitted
//   expnd_otpt_end_o   : out final beat of the block (j = 64-LANES)
// Build option: define SM3_EXPND_PRELOAD_EN to add a shadow block buffer so
// the next block loads while the current one is being expanded.
module sm3_msg_expnd
    import sm3_expnd_pkg::*;
#(
    parameter int INPT_DW = 32,
    parameter int LANES   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INPT_DW-1:0]    pad_inpt_d_i,
    input  logic                  pad_inpt_vld_i,
    input  logic                  pad_inpt_lst_i,
    output logic                  pad_inpt_rdy_o,
    output logic [32*LANES-1:0]   expnd_otpt_wj_o,
    output logic [32*LANES-1:0]   expnd_otpt_wjj_o,
    output logic                  expnd_otpt_vld_o,
    input  logic                  expnd_otpt_rdy_i,
    output logic                  expnd_otpt_lst_o,
    output logic                  expnd_otpt_end_o
);

    localparam int WPB   = INPT_DW / 32;
    localparam int BEATS = 512 / INPT_DW;

    if (!(INPT_DW == 32 || INPT_DW == 64)) begin : g_bad_dw
        $error("sm3_msg_expnd: INPT_DW must be 32 or 64");
    end
    if (!(LANES == 1 || LANES == 2)) begin : g_bad_lanes
        $error("sm3_msg_expnd: LANES must be 1 or 2");
    end

    state_t      state;
    logic [31:0] win [SM3_BLK_W];   // win[0] = W[j]
    logic [3:0]  beat_cnt;
    logic [5:0]  j_cnt;
    logic        lst_q;

    logic [31:0] in_w  [WPB];
    logic [31:0] new_w [LANES];
    logic        in_fire, out_fire, last_in, last_out;

    always_comb begin
        for (int k = 0; k < WPB; k++) begin
            in_w[k] = pad_inpt_d_i[INPT_DW-1-32*k -: 32];
        end
    end

    // W[j+16+k] only reads window words, so both lanes evaluate in parallel.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sm3_expnd_wgen u_wgen (
            .w_m16 (win[k]),
            .w_m13 (win[k+3]),
            .w_m9  (win[k+7]),
            .w_m6  (win[k+10]),
            .w_m3  (win[k+13]),
            .w_new (new_w[k])
        );
    end

    assign expnd_otpt_vld_o = (state == EXPND);
    assign in_fire  = pad_inpt_vld_i && pad_inpt_rdy_o;
    assign out_fire = expnd_otpt_vld_o && expnd_otpt_rdy_i;
    assign last_in  = (beat_cnt == 4'(BEATS - 1));
    assign last_out = (j_cnt == 6'(SM3_OUT_W - LANES));

    assign expnd_otpt_lst_o = expnd_otpt_vld_o && lst_q;
    assign expnd_otpt_end_o = expnd_otpt_vld_o && last_out;

    always_comb begin
        expnd_otpt_wj_o  = '0;
        expnd_otpt_wjj_o = '0;
        if (expnd_otpt_vld_o) begin
            for (int k = 0; k < LANES; k++) begin
                expnd_otpt_wj_o[32*(LANES-k)-1 -: 32]  = win[k];
                expnd_otpt_wjj_o[32*(LANES-k)-1 -: 32] = win[k] ^ win[k+4];
            end
        end
    end

`ifdef SM3_EXPND_PRELOAD_EN
    logic [31:0] sh      [SM3_BLK_W];
    logic [31:0] sh_next [SM3_BLK_W];
    logic [31:0] blk_w   [SM3_BLK_W];
    logic        sh_full, sh_lst, blk_rdy, blk_lst, swap;

    always_comb begin
        for (int i = 0; i < SM3_BLK_W - WPB; i++) sh_next[i] = sh[i+WPB];
        for (int k = 0; k < WPB; k++) sh_next[SM3_BLK_W-WPB+k] = in_w[k];
        for (int i = 0; i < SM3_BLK_W; i++) blk_w[i] = sh_full ? sh[i] : sh_next[i];
    end

    // A block is ready either parked in the shadow or completing this cycle.
    assign blk_rdy = sh_full || (in_fire && last_in);
    assign blk_lst = sh_full ? sh_lst : pad_inpt_lst_i;
    assign swap    = blk_rdy && ((state == LOAD) || (out_fire && last_out));
    assign pad_inpt_rdy_o = !rst && !sh_full;
`else
    assign pad_inpt_rdy_o = !rst && (state == LOAD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            j_cnt    <= '0;
            lst_q    <= 1'b0;
            for (int i = 0; i < SM3_BLK_W; i++) win[i] <= '0;
`ifdef SM3_EXPND_PRELOAD_EN
            sh_full  <= 1'b0;
            sh_lst   <= 1'b0;
            for (int i = 0; i < SM3_BLK_W; i++) sh[i] <= '0;
`endif
        end else begin
`ifdef SM3_EXPND_PRELOAD_EN
            if (in_fire) begin
                for (int i = 0; i < SM3_BLK_W; i++) sh[i] <= sh_next[i];
                beat_cnt <= last_in ? 4'd0 : beat_cnt + 4'd1;
            end
            if (swap) begin
                sh_full <= 1'b0;
            end else if (in_fire && last_in) begin
                sh_full <= 1'b1;
                sh_lst  <= pad_inpt_lst_i;
            end
`endif
            case (state)
                LOAD: begin
`ifdef SM3_EXPND_PRELOAD_EN
                    if (swap) begin
                        for (int i = 0; i < SM3_BLK_W; i++) win[i] <= blk_w[i];
                        lst_q <= blk_lst;
                        j_cnt <= '0;
                        state <= EXPND;
                    end
`else
                    if (in_fire) begin
                        for (int i = 0; i < SM3_BLK_W - WPB; i++) win[i] <= win[i+WPB];
                        for (int k = 0; k < WPB; k++) win[SM3_BLK_W-WPB+k] <= in_w[k];
                        beat_cnt <= last_in ? 4'd0 : beat_cnt + 4'd1;
                        if (last_in) begin
                            lst_q <= pad_inpt_lst_i;
                            j_cnt <= '0;
                            state <= EXPND;
                        end
                    end
`endif
                end
                EXPND: begin
                    if (out_fire) begin
`ifdef SM3_EXPND_PRELOAD_EN
                        if (swap) begin
                            // Next block drops straight in: no idle cycle.
                            for (int i = 0; i < SM3_BLK_W; i++) win[i] <= blk_w[i];
                            lst_q <= blk_lst;
                        end else
`endif
                        begin
                            for (int i = 0; i < SM3_BLK_W - LANES; i++) win[i] <= win[i+LANES];
                            for (int k = 0; k < LANES; k++) win[SM3_BLK_W-LANES+k] <= new_w[k];
                        end
                        if (last_out) begin
                            j_cnt <= '0;
`ifdef SM3_EXPND_PRELOAD_EN
                            if (!swap) state <= LOAD;
`else
                            state <= LOAD;
`endif
                        end else begin
                            j_cnt <= j_cnt + 6'(LANES);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
